// File: rtl/flt_pkg.sv
// flt_pkg: shared types and constants for the half-float to integer converter
package flt_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, FINISH} state_t;
  typedef enum logic [1:0] {C_ZERO, C_RIGHT, C_LEFT, C_SPECIAL} class_t;
  localparam int EXP_W = 5;
  localparam int MANT_W = 10;
  localparam int INT_W = 16;
  localparam int EXP_ALIGN = 25;
  localparam int EXP_HALF = 14;
  localparam int EXP_SAT = 30;
  localparam logic [INT_W-1:0] INT_MAX = 16'h7FFF;
  localparam logic [INT_W-1:0] INT_MIN = 16'h8000;
endpackage

// File: rtl/flt_classify.sv
// flt_classify: sorts a half float into zero, right/left shift or preset special result
module flt_classify
  import flt_pkg::*;
#(
  parameter int BIAS = 15,
  parameter logic [INT_W-1:0] NAN_VAL = 16'h0000
) (
  input  logic [INT_W-1:0] Flt_in,
  output class_t           cls,
  output logic             dir,
  output logic [3:0]       cnt,
  output logic [INT_W-1:0] preset,
  output logic             ovf
);
  localparam int ALIGN = BIAS + MANT_W;
  logic s;
  logic [EXP_W-1:0] e;
  logic [MANT_W-1:0] m;
  assign {s, e, m} = Flt_in;
  // exponent decides the path; specials carry their final result and overflow flag
  always_comb begin
    cls = C_ZERO;
    dir = 1'b0;
    cnt = '0;
    preset = '0;
    ovf = 1'b0;
    if (int'(e) < EXP_HALF) begin
      cls = C_ZERO;
    end else if (int'(e) < ALIGN) begin
      cls = C_RIGHT;
      cnt = 4'(ALIGN - int'(e));
    end else if (int'(e) < EXP_SAT) begin
      cls = C_LEFT;
      dir = 1'b1;
      cnt = 4'(int'(e) - ALIGN);
    end else begin
      cls = C_SPECIAL;
      preset = (int'(e) == EXP_SAT + 1 && m != '0) ? NAN_VAL : s ? INT_MIN : INT_MAX;
      ovf = !(int'(e) == EXP_SAT && s && m == '0);
    end
  end
endmodule

// File: rtl/flt2int.sv
// flt2int: sequential half float to int16 converter with round-to-nearest-even and saturation
module flt2int
  import flt_pkg::*;
#(
  parameter int BIAS = 15,
  parameter logic [INT_W-1:0] NAN_VAL = 16'h0000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [INT_W-1:0] Flt_in,
  output logic [INT_W-1:0] Int_out,
  output logic             Done,
  output logic             Ovf
);
  class_t cls;
  logic dir_c, ovf_c;
  logic [3:0] cnt_c;
  logic [INT_W-1:0] preset;
  state_t state;
  logic s, dir, guard, sticky, ovf_r;
  logic [3:0] cnt;
  logic [INT_W-1:0] mag;
  flt_classify #(.BIAS(BIAS), .NAN_VAL(NAN_VAL)) u_cls (
    .Flt_in(Flt_in),
    .cls(cls),
    .dir(dir_c),
    .cnt(cnt_c),
    .preset(preset),
    .ovf(ovf_c)
  );
  // control FSM and magnitude datapath; specials are stored as an unsigned preset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      s <= 1'b0;
      dir <= 1'b0;
      guard <= 1'b0;
      sticky <= 1'b0;
      ovf_r <= 1'b0;
      cnt <= '0;
      mag <= '0;
      Int_out <= '0;
      Done <= 1'b0;
      Ovf <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          s <= Flt_in[INT_W-1] && cls != C_SPECIAL;
          mag <= cls == C_SPECIAL ? preset : cls == C_ZERO ? '0 : INT_W'({1'b1, Flt_in[MANT_W-1:0]});
          cnt <= cnt_c;
          dir <= dir_c;
          guard <= 1'b0;
          sticky <= 1'b0;
          ovf_r <= ovf_c;
          state <= (cls == C_RIGHT || (cls == C_LEFT && cnt_c != '0)) ? SHIFT : cls == C_LEFT ? ROUND : FINISH;
        end
        SHIFT: begin
          if (dir) begin
            mag <= mag << 1;
          end else begin
            sticky <= sticky | guard;
            guard <= mag[0];
            mag <= mag >> 1;
          end
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ROUND;
        end
        ROUND: begin
          mag <= mag + INT_W'(guard & (sticky | mag[0]));
          state <= FINISH;
        end
        FINISH: begin
          Int_out <= s ? -mag : mag;
          Done <= 1'b1;
          Ovf <= ovf_r;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_flt2int.sv
// tb_flt2int: randomized and directed checks of flt2int against an arithmetic reference model
module tb_flt2int;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Start = 1'b0;
  logic [15:0] Flt_in = '0;
  logic [15:0] Int_out;
  logic Done, Ovf;
  int checks = 0;
  int failures = 0;

  flt2int dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Flt_in(Flt_in),
    .Int_out(Int_out),
    .Done(Done),
    .Ovf(Ovf)
  );

  always #5 Clk = ~Clk;

  function automatic void model(input logic [15:0] f, output logic [15:0] r, output logic o, output int lat);
    int e = int'(f[14:10]);
    int m = int'(f[9:0]);
    int sig = 1024 + m;
    logic sgn = f[15];
    o = 1'b0;
    if (e <= 13) begin
      r = 16'h0000;
      lat = 1;
    end else if (e <= 24) begin
      int k = 25 - e;
      int q = sig >> k;
      int rem = sig - (q << k);
      int half = 1 << (k - 1);
      if (rem > half || (rem == half && q % 2 == 1)) q++;
      r = sgn ? 16'(-q) : 16'(q);
      lat = 2 + k;
    end else if (e <= 29) begin
      int v = sig << (e - 25);
      r = sgn ? 16'(-v) : 16'(v);
      lat = 2 + e - 25;
    end else if (e == 31 && m != 0) begin
      r = 16'h0000;
      o = 1'b1;
      lat = 1;
    end else begin
      r = sgn ? 16'h8000 : 16'h7FFF;
      o = !(e == 30 && sgn && m == 0);
      lat = 1;
    end
  endfunction

  task automatic convert(input logic [15:0] f);
    logic [15:0] er;
    logic eo;
    int el, lat;
    model(f, er, eo, el);
    Start = 1'b1;
    Flt_in = f;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    Flt_in = 16'($urandom);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge Clk);
      #1;
      if (Done) lat = k;
    end
    checks++;
    if (lat != el) begin
      failures++;
      $display("FAIL latency f=%h got=%0d exp=%0d", f, lat, el);
    end
    checks++;
    if (Int_out !== er) begin
      failures++;
      $display("FAIL int_out f=%h got=%h exp=%h", f, Int_out, er);
    end
    checks++;
    if (Ovf !== eo) begin
      failures++;
      $display("FAIL ovf f=%h got=%b exp=%b", f, Ovf, eo);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (Done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse f=%h got=%b exp=0", f, Done);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({Int_out, Done, Ovf} !== 18'h0) begin
      failures++;
      $display("FAIL reset got=%h/%b/%b exp=0000/0/0", Int_out, Done, Ovf);
    end
    Reset = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_directed();
    logic [15:0] v [15] = '{16'h3C00, 16'h3800, 16'h3E00, 16'h4100, 16'h3A00, 16'hC000, 16'h4F00,
                            16'h77FF, 16'hF800, 16'h7800, 16'hFC00, 16'h7E00, 16'h0001, 16'h0000, 16'h6400};
    foreach (v[i]) convert(v[i]);
  endtask

  task automatic test_random();
    logic [15:0] f;
    for (int i = 0; i < 300; i++) begin
      f = (i % 2 == 0) ? 16'($urandom) : {1'($urandom), 5'($urandom_range(31, 12)), 10'($urandom)};
      convert(f);
    end
  endtask

  task automatic test_ignore_start();
    int lat = 0;
    int extra = 0;
    Start = 1'b1;
    Flt_in = 16'h3C00;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Start = 1'b1;
    Flt_in = 16'h4F00;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    for (int k = 5; k <= 20 && lat == 0; k++) begin
      @(posedge Clk);
      #1;
      if (Done) lat = k;
    end
    checks++;
    if (lat != 12 || Int_out !== 16'h0001) begin
      failures++;
      $display("FAIL ignore_start lat=%0d out=%h exp lat=12 out=0001", lat, Int_out);
    end
    repeat (15) begin
      @(posedge Clk);
      #1;
      if (Done) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL ignore_extra_done got=%0d exp=0", extra);
    end
  endtask

  task automatic test_reset_mid();
    convert(16'h7800);
    Start = 1'b1;
    Flt_in = 16'h3C00;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    checks++;
    if ({Int_out, Done, Ovf} !== 18'h0) begin
      failures++;
      $display("FAIL reset_mid got=%h/%b/%b exp=0000/0/0", Int_out, Done, Ovf);
    end
    convert(16'hC000);
  endtask

  task automatic test_back_to_back();
    int d1 = 0;
    int d2 = 0;
    Start = 1'b1;
    Flt_in = 16'h4100;
    @(posedge Clk);
    #1;
    for (int k = 1; k <= 20 && d1 == 0; k++) begin
      @(posedge Clk);
      #1;
      if (Done) d1 = k;
    end
    checks++;
    if (d1 != 11 || Int_out !== 16'h0002) begin
      failures++;
      $display("FAIL b2b_first lat=%0d out=%h exp lat=11 out=0002", d1, Int_out);
    end
    for (int k = 1; k <= 30 && d2 == 0; k++) begin
      @(posedge Clk);
      #1;
      if (Done) d2 = k;
    end
    Start = 1'b0;
    checks++;
    if (d2 != 12 || Int_out !== 16'h0002) begin
      failures++;
      $display("FAIL b2b_second gap=%0d out=%h exp gap=12 out=0002", d2, Int_out);
    end
    repeat (15) @(posedge Clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
